// File: rtl/lookahead_adder_pipe.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// lookahead_adder_pipe
//
// Pipelined carry-lookahead adder/subtractor with valid/ready handshakes on
// both sides. The operand is split into NG = WIDTH/GROUP lookahead groups.
// Each group is resolved in its own pipeline stage. The group carry is
// registered between stages.
//
// Each stage forwards three things:
//   - the result bits resolved so far, which grow by GROUP bits per stage;
//   - the operand bits that no stage has consumed yet, which shrink by
//     GROUP bits per stage (skew buffer);
//   - a valid bit.
//
// Backpressure is a single global stall: while the last stage holds a result
// that downstream is not taking, every stage holds. Bubbles are not squeezed
// out.
//
// Parameters
//   WIDTH  operand/result width, must be a multiple of GROUP
//   GROUP  bits per lookahead group (one pipeline stage per group)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset, clears all stage registers
//   in_valid   operand beat present
//   in_ready   block can accept a beat (combinational, = ~stall)
//   sub        0 = a + b + c_in, 1 = a - b
//   c_in       carry-in, add mode only
//   a, b       operands
//   out_valid  result beat present
//   out_ready  downstream accepts the result
//   s          sum/difference modulo 2^WIDTH
//   c_out      carry out of the MSB (subtract mode: 1 = no borrow)
//   ovf        two's-complement overflow
// -----------------------------------------------------------------------------
module lookahead_adder_pipe #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sub,
    input  logic             c_in,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf
);

    localparam int NG = WIDTH / GROUP;

    logic             stall;
    logic             accept;
    logic [WIDTH-1:0] bb_in;
    logic             ci_in;

    // Lookahead carries for one group. Each c[j+1] is the flat sum-of-products
    //   g[j] | p[j]g[j-1] | ... | p[j]..p[1]g[0] | p[j]..p[0]c0
    // so every carry is two logic levels deep, not a ripple chain.
    // Returns c[GROUP:0] with c[0] = c0.
    function automatic logic [GROUP:0] lookahead(
        input logic [GROUP-1:0] p,
        input logic [GROUP-1:0] g,
        input logic             c0
    );
        logic [GROUP:0] c;
        logic           term;
        c    = '0;
        c[0] = c0;
        for (int unsigned j = 0; j < GROUP; j++) begin
            // Term where c0 propagates through bits 0..j.
            term = c0;
            for (int unsigned m = 0; m <= j; m++) begin
                term = term & p[m];
            end
            c[j+1] = term;
            // Terms where bit m generates and bits m+1..j propagate.
            for (int unsigned m = 0; m <= j; m++) begin
                term = g[m];
                for (int unsigned n = m + 1; n <= j; n++) begin
                    term = term & p[n];
                end
                c[j+1] = c[j+1] | term;
            end
        end
        return c;
    endfunction

    // Handshake control and operand conditioning.
    always_comb begin
        stall    = out_valid & ~out_ready;
        in_ready = ~stall;
        accept   = in_valid & in_ready;
        bb_in    = sub ? ~b : b;
        ci_in    = sub | c_in;
    end

    for (genvar k = 0; k < NG; k++) begin : g_stage
        // Result bits already resolved by earlier stages.
        localparam int LO_W  = k * GROUP;
        // Operand bits arriving at this stage; the low GROUP bits belong to it.
        localparam int OP_W  = WIDTH - k * GROUP;
        // Operand bits forwarded to later stages.
        localparam int REM_W = OP_W - GROUP;

        logic [OP_W-1:0]       op_a;
        logic [OP_W-1:0]       op_bb;
        logic                  op_c;
        logic                  op_v;
        logic [GROUP-1:0]      p;
        logic [GROUP-1:0]      g;
        logic [GROUP:0]        c;
        logic [LO_W+GROUP-1:0] sum_d;
        logic [LO_W+GROUP-1:0] sum_q;
        logic                  carry_d;
        logic                  carry_q;
        logic                  valid_d;
        logic                  valid_q;

        if (k == 0) begin : g_src
            // First stage is fed directly from the input port. With no beat
            // accepted it loads valid = 0, which inserts a bubble.
            always_comb begin
                op_a  = a;
                op_bb = bb_in;
                op_c  = ci_in;
                op_v  = accept;
                sum_d = p ^ c[GROUP-1:0];
            end
        end else begin : g_src
            // Later stages take the previous stage's skew buffer and group
            // carry. Their new sum bits go above the bits already resolved.
            always_comb begin
                op_a  = g_stage[k-1].g_skew.a_q;
                op_bb = g_stage[k-1].g_skew.bb_q;
                op_c  = g_stage[k-1].carry_q;
                op_v  = g_stage[k-1].valid_q;
                sum_d = {p ^ c[GROUP-1:0], g_stage[k-1].sum_q};
            end
        end

        always_comb begin
            p       = op_a[GROUP-1:0] ^ op_bb[GROUP-1:0];
            g       = op_a[GROUP-1:0] & op_bb[GROUP-1:0];
            c       = lookahead(p, g, op_c);
            carry_d = c[GROUP];
            valid_d = op_v;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sum_q   <= '0;
                carry_q <= 1'b0;
                valid_q <= 1'b0;
            end else if (!stall) begin
                sum_q   <= sum_d;
                carry_q <= carry_d;
                valid_q <= valid_d;
            end
        end

        if (REM_W > 0) begin : g_skew
            logic [REM_W-1:0] a_d;
            logic [REM_W-1:0] a_q;
            logic [REM_W-1:0] bb_d;
            logic [REM_W-1:0] bb_q;

            always_comb begin
                a_d  = op_a[OP_W-1:GROUP];
                bb_d = op_bb[OP_W-1:GROUP];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q  <= '0;
                    bb_q <= '0;
                end else if (!stall) begin
                    a_q  <= a_d;
                    bb_q <= bb_d;
                end
            end
        end else begin : g_last
            // The MSB lives in the last group, so only this stage can see the
            // carry into the MSB needed for the overflow flag.
            logic ovf_d;
            logic ovf_q;

            always_comb begin
                ovf_d = c[GROUP] ^ c[GROUP-1];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (!stall) begin
                    ovf_q <= ovf_d;
                end
            end
        end
    end

    always_comb begin
        s         = g_stage[NG-1].sum_q;
        c_out     = g_stage[NG-1].carry_q;
        ovf       = g_stage[NG-1].g_last.ovf_q;
        out_valid = g_stage[NG-1].valid_q;
    end

endmodule

// File: tb/tb_lookahead_adder_pipe.sv
`timescale 1ns/1ps
module tb_lookahead_adder_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        sub;
    logic        c_in;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] s;
    logic        c_out;
    logic        ovf;

    int n_vec;
    int n_bad;

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        o;
    } res_t;

    res_t exp_q[$];

    lookahead_adder_pipe #(.WIDTH(16), .GROUP(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sub      (sub),
        .c_in     (c_in),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .s        (s),
        .c_out    (c_out),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the operand values.
    function automatic res_t model(input logic [15:0] x, input logic [15:0] y,
                                   input logic sb, input logic ci);
        res_t r;
        int   ux, uy, sx, sy, fu, fs;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (sb) begin
            fu  = ux - uy;
            fs  = sx - sy;
            r.c = (ux >= uy);
        end else begin
            fu  = ux + uy + (ci ? 1 : 0);
            fs  = sx + sy + (ci ? 1 : 0);
            r.c = (fu > 65535);
        end
        r.s = fu[15:0];
        r.o = (fs > 32767) || (fs < -32768);
        return r;
    endfunction

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare process: checks every meaningful output cycle against the model
    // queue, and records accepted beats.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            chk1("rst_out_valid", out_valid, 1'b0);
        end else begin
            chk1("in_ready_rule", in_ready, !(out_valid && !out_ready));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL spurious_result: got s=%h with nothing outstanding, required none at %0t",
                             s, $time);
                end else begin
                    chk16("model_s", s, exp_q[0].s);
                    chk1("model_c_out", c_out, exp_q[0].c);
                    chk1("model_ovf", ovf, exp_q[0].o);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(a, b, sub, c_in));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One isolated beat: exact latency plus hand-computed result.
    task automatic single(input string nm, input logic [15:0] xa, input logic [15:0] xb,
                          input logic xs, input logic xc, input logic [15:0] es,
                          input logic ec, input logic eo);
        a = xa; b = xb; sub = xs; c_in = xc; in_valid = 1'b1; out_ready = 1'b1;
        tick;                              // accept edge t
        in_valid = 1'b0;
        tick; tick;                        // t+1, t+2
        chk1({nm, "_not_yet"}, out_valid, 1'b0);
        tick;                              // t+3
        chk1({nm, "_valid"}, out_valid, 1'b1);
        chk16({nm, "_s"}, s, es);
        chk1({nm, "_c_out"}, c_out, ec);
        chk1({nm, "_ovf"}, ovf, eo);
        tick;                              // transfer edge
        chk1({nm, "_gone"}, out_valid, 1'b0);
    endtask

    task automatic drain(input string nm);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int i = 0; i < 30 && (exp_q.size() > 0 || out_valid); i++) tick;
        n_vec++;
        if (exp_q.size() != 0 || out_valid) begin
            n_bad++;
            $display("FAIL %s_drain: got %0d outstanding expected 0", nm, exp_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst_n = 1'b0; in_valid = 1'b0; sub = 1'b0; c_in = 1'b0;
        a = '0; b = '0; out_ready = 1'b0;
        #3;
        chk1("reset_out_valid", out_valid, 1'b0);
        chk1("reset_in_ready", in_ready, 1'b1);
        chk16("reset_s", s, 16'h0000);
        chk1("reset_c_out", c_out, 1'b0);
        chk1("reset_ovf", ovf, 1'b0);
        @(posedge clk); #3 rst_n = 1'b1;
        tick;

        // Directed single beats.
        single("carry_all", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        single("sovf_add", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        single("cin_add", 16'h1234, 16'h0000, 1'b0, 1'b1, 16'h1235, 1'b0, 1'b0);
        single("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        single("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);
        single("sub_zero", 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);

        // Streaming: 8 back-to-back beats, results on 8 consecutive cycles.
        out_ready = 1'b1; sub = 1'b0; c_in = 1'b0;
        for (int i = 0; i < 13; i++) begin
            in_valid = (i < 8);
            a = 16'(16'h1111 * (i + 1));
            b = 16'(i + 1);
            tick;                          // edge i
            chk1("stream_valid", out_valid, (i >= 3 && i <= 10));
            if (i >= 3 && i <= 10) chk16("stream_s", s, 16'(16'h1112 * (i - 2)));
        end
        in_valid = 1'b0;
        drain("stream");

        // Backpressure: fill, then hold out_ready low for 3 cycles.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; a = 16'(16'h0100 * (i + 1)); b = 16'(i); sub = 1'b0; c_in = 1'b0;
            tick;
        end
        chk1("bp_full_valid", out_valid, 1'b1);
        out_ready = 1'b0; a = 16'hAAAA; b = 16'h0001;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk1("bp_in_ready", in_ready, 1'b0);
            chk1("bp_out_valid", out_valid, 1'b1);
            chk16("bp_s_held", s, 16'h0100);
            tick;
        end
        in_valid = 1'b0;
        drain("bp");

        // Randomized ready/valid against the model.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            a = 16'($urandom); b = 16'($urandom);
            sub = 1'($urandom_range(0, 1)); c_in = 1'($urandom_range(0, 1));
            tick;
        end
        drain("random");

        // Reset mid-flight with 4 beats held in the pipeline.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; a = 16'(16'h0101 * (i + 1)); b = 16'(16'h0202 * (i + 1));
            sub = 1'b0; c_in = 1'b0;
            tick;
        end
        in_valid = 1'b0;
        chk1("midrst_pre_valid", out_valid, 1'b1);
        chk16("midrst_pre_s", s, 16'h0303);
        #2 rst_n = 1'b0;
        #1;
        chk1("midrst_out_valid", out_valid, 1'b0);
        chk16("midrst_s", s, 16'h0000);
        chk1("midrst_in_ready", in_ready, 1'b1);
        @(posedge clk); #3 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick;
            chk1("post_rst_no_result", out_valid, 1'b0);
            chk1("post_rst_in_ready", in_ready, 1'b1);
        end
        single("post_rst_beat", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
        drain("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
